// File: rtl/gelato_scoreboard_if.sv
// Issue/writeback request bundle between the warp scheduler, writeback and the scoreboard.
// Handshake: a request is taken on a clk edge where valid and the global rdy are both high; producers hold valid until then.
interface gelato_scoreboard_if #(
    parameter int WARP_NUM = 4,
    parameter int REG_W    = 5
);
    localparam int WW = $clog2(WARP_NUM);

    logic          set_valid;
    logic [WW-1:0] set_warp;
    logic [REG_W-1:0] set_reg;
    logic          wb_valid;
    logic [WW-1:0] wb_warp;
    logic [REG_W-1:0] wb_reg;

    modport master (
        output set_valid, set_warp, set_reg,
        output wb_valid, wb_warp, wb_reg
    );

    modport slave (
        input set_valid, set_warp, set_reg,
        input wb_valid, wb_warp, wb_reg
    );
endinterface

// File: rtl/gelato_scoreboard.sv
// Per-warp dirty-register scoreboard: issue marks rd pending, writeback frees it.
// Slot value 0 means free; full/count are computed from next-state entries so they track regs exactly.
module gelato_scoreboard #(
    parameter int WARP_NUM        = 4,
    parameter int SCOREBOARD_SIZE = 4,
    parameter int REG_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rdy,
    gelato_scoreboard_if.slave sb,
    output logic [WARP_NUM*SCOREBOARD_SIZE*REG_W-1:0]        regs,
    output logic [WARP_NUM-1:0]                              full,
    output logic [WARP_NUM*($clog2(SCOREBOARD_SIZE)+1)-1:0]  count,
    output logic err_ovf,
    output logic err_unf
);
    localparam int WW = $clog2(WARP_NUM);
    localparam int CW = $clog2(SCOREBOARD_SIZE) + 1;

    typedef logic [REG_W-1:0] reg_t;

    reg_t          ent_q [WARP_NUM][SCOREBOARD_SIZE];
    reg_t          ent_d [WARP_NUM][SCOREBOARD_SIZE];
    logic [CW-1:0] cnt_q [WARP_NUM];
    logic [CW-1:0] cnt_d [WARP_NUM];
    logic [WARP_NUM-1:0] full_q, full_d;
    logic ovf_q, ovf_d, unf_q, unf_d;

    logic do_clr, do_set, hit, dup, placed;

    always_comb begin
        ent_d  = ent_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        full_d = '0;
        do_clr = 1'b0;
        do_set = 1'b0;
        hit    = 1'b0;
        dup    = 1'b0;
        placed = 1'b0;
        for (int w = 0; w < WARP_NUM; w++) begin
            cnt_d[w] = '0;
            do_clr = rdy && sb.wb_valid  && (sb.wb_warp  == WW'(w)) && (sb.wb_reg  != '0);
            do_set = rdy && sb.set_valid && (sb.set_warp == WW'(w)) && (sb.set_reg != '0);
            hit    = 1'b0;
            dup    = 1'b0;
            placed = 1'b0;
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (do_clr && ent_q[w][s] == sb.wb_reg) begin
                    ent_d[w][s] = '0;
                    hit         = 1'b1;
                end
            end
            if (do_clr && !hit) unf_d = 1'b1;
            // An entry about to be cleared by the same-warp writeback does not count as a duplicate.
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (ent_q[w][s] == sb.set_reg && !(do_clr && sb.wb_reg == sb.set_reg)) dup = 1'b1;
            end
            // Free slot is picked from the pre-clear state: a hole opened this cycle is reused next cycle.
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (do_set && !dup && !placed && ent_q[w][s] == '0) begin
                    ent_d[w][s] = sb.set_reg;
                    placed      = 1'b1;
                end
            end
            if (do_set && !dup && !placed) ovf_d = 1'b1;
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (ent_d[w][s] != '0) cnt_d[w] = cnt_d[w] + CW'(1);
            end
            full_d[w] = (cnt_d[w] == CW'(SCOREBOARD_SIZE));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q  <= '{default: '0};
            cnt_q  <= '{default: '0};
            full_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    for (genvar w = 0; w < WARP_NUM; w++) begin : g_warp
        for (genvar s = 0; s < SCOREBOARD_SIZE; s++) begin : g_slot
            assign regs[(w*SCOREBOARD_SIZE+s)*REG_W +: REG_W] = ent_q[w][s];
        end
        assign count[w*CW +: CW] = cnt_q[w];
    end

    assign full    = full_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
endmodule

// File: tb/tb_gelato_scoreboard.sv
// Directed bench for gelato_scoreboard: drivers push hand-computed expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gelato_scoreboard;
    localparam int WN = 4;
    localparam int SZ = 4;
    localparam int RW = 5;
    localparam int CW = 3;
    localparam int W  = WN*SZ*RW + WN + WN*CW + 2;

    logic clk;
    logic rst_n;
    logic rdy;
    logic [WN*SZ*RW-1:0] regs;
    logic [WN-1:0]       full;
    logic [WN*CW-1:0]    count;
    logic err_ovf, err_unf;

    gelato_scoreboard_if #(.WARP_NUM(WN), .REG_W(RW)) bus ();

    gelato_scoreboard #(.WARP_NUM(WN), .SCOREBOARD_SIZE(SZ), .REG_W(RW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rdy     (rdy),
        .sb      (bus.slave),
        .regs    (regs),
        .full    (full),
        .count   (count),
        .err_ovf (err_ovf),
        .err_unf (err_unf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // hand-maintained expected state
    int   e_slot [WN][SZ];
    logic e_ovf, e_unf;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [W-1:0] snap();
        logic [WN*SZ*RW-1:0] r;
        logic [WN-1:0]       f;
        logic [WN*CW-1:0]    c;
        int n;
        r = '0;
        f = '0;
        c = '0;
        for (int w = 0; w < WN; w++) begin
            n = 0;
            for (int s = 0; s < SZ; s++) begin
                r[(w*SZ+s)*RW +: RW] = RW'(e_slot[w][s]);
                if (e_slot[w][s] != 0) n++;
            end
            c[w*CW +: CW] = CW'(n);
            f[w] = (n == SZ);
        end
        return {r, f, c, e_ovf, e_unf};
    endfunction

    task automatic clear_exp();
        for (int w = 0; w < WN; w++)
            for (int s = 0; s < SZ; s++) e_slot[w][s] = 0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
    endtask

    task automatic expect_now(input string tag);
        exp_q.push_back(snap());
        tag_q.push_back(tag);
    endtask

    // driver: present one request set for one edge, then queue the expected post-edge state
    task automatic step(input string tag, input logic sv, input int sw, input int sr,
                        input logic wv, input int ww, input int wr, input logic r);
        bus.set_valid = sv;
        bus.set_warp  = 2'(sw);
        bus.set_reg   = 5'(sr);
        bus.wb_valid  = wv;
        bus.wb_warp   = 2'(ww);
        bus.wb_reg    = 5'(wr);
        rdy           = r;
        @(posedge clk);
        #1;
        expect_now(tag);
        bus.set_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        rdy           = 1'b1;
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] exp, got;
        string tag;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                got = {regs, full, count, err_ovf, err_unf};
                n_total++;
                if (got === exp) n_pass++;
                else $display("FAIL %s: got %h required %h", tag, got, exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        bus.set_valid = 1'b0;
        bus.set_warp  = '0;
        bus.set_reg   = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_warp   = '0;
        bus.wb_reg    = '0;
        clear_exp();
        #1;
        expect_now("reset_held");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset", 0, 0, 0, 0, 0, 0, 1);

        // basic allocation in w0
        e_slot[0][0] = 5;  step("w0_set_r5", 1, 0, 5, 0, 0, 0, 1);
        e_slot[0][1] = 6;  step("w0_set_r6", 1, 0, 6, 0, 0, 0, 1);
        e_slot[0][2] = 7;  step("w0_set_r7", 1, 0, 7, 0, 0, 0, 1);
        step("w0_dup_r5", 1, 0, 5, 0, 0, 0, 1);

        // fill w1, overflow, then free a middle slot
        for (int i = 1; i <= 4; i++) begin
            e_slot[1][i-1] = i;
            step($sformatf("w1_fill_r%0d", i), 1, 1, i, 0, 0, 0, 1);
        end
        e_ovf = 1'b1;      step("w1_overflow_r9", 1, 1, 9, 0, 0, 0, 1);
        e_slot[1][1] = 0;  step("w1_wb_r2", 0, 0, 0, 1, 1, 2, 1);
        e_slot[1][1] = 9;  step("w1_reuse_hole_r9", 1, 1, 9, 0, 0, 0, 1);
        e_slot[1][1] = 0;  step("w1_full_set_and_wb", 1, 1, 11, 1, 1, 9, 1);

        // same-warp set and clear of the same register
        e_slot[2][0] = 3;  step("w2_set_r3", 1, 2, 3, 0, 0, 0, 1);
        e_slot[2][0] = 0;
        e_slot[2][1] = 3;  step("w2_set_wb_same_r3", 1, 2, 3, 1, 2, 3, 1);

        // different warps in one cycle
        e_slot[3][0] = 12;
        e_slot[2][1] = 0;  step("w3_set_w2_wb", 1, 3, 12, 1, 2, 3, 1);

        // underflow and x0
        e_unf = 1'b1;      step("w3_wb_r8_unf", 0, 0, 0, 1, 3, 8, 1);
        step("w0_set_r0", 1, 0, 0, 0, 0, 0, 1);
        step("w0_wb_r0", 0, 0, 0, 1, 0, 0, 1);

        // enable held low with a pending set
        for (int i = 0; i < 3; i++) step($sformatf("rdy_low_%0d", i), 1, 0, 10, 0, 0, 0, 0);
        e_slot[0][3] = 10; step("rdy_high_r10", 1, 0, 10, 0, 0, 0, 1);

        // asynchronous reset between edges
        @(negedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_exp();
        expect_now("async_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        e_slot[0][0] = 1;  step("post_reset_set_r1", 1, 0, 1, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            $display("FAIL drain: got %0d pending checks required 0", exp_q.size());
            n_total += exp_q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
